// File: rtl/branch_predictor_bht.sv
// branch_predictor_bht
//
// Branch history table of saturating counters, indexed by the low PC bits.
// In gshare mode the index is additionally XOR-ed with a non-speculative
// global history register. The fetch stage looks up a prediction
// combinationally. The execute stage writes back the resolved outcome together
// with the index that was carried down the pipeline. On a mispredict the block
// raises a one-cycle flush request. Saturating statistics count resolved
// branches and mispredicts.
//
// Ports:
//   clk              clock, all state changes on the rising edge
//   rst              asynchronous active-high reset
//   pred_pc          fetch-stage PC to predict
//   pred_taken       prediction for pred_pc (combinational)
//   pred_idx         table index used; carried by the pipeline to EX
//   upd_valid        a branch is resolved in EX this cycle
//   upd_idx          index carried with the resolving branch
//   upd_taken        actual branch outcome
//   upd_pred_taken   prediction that was made for the resolving branch
//   flush_taken      predicted not-taken but taken: redirect to target
//   flush_not_taken  predicted taken but not taken: redirect to fall-through
//   br_count         resolved branches, saturating
//   mis_count        mispredicts, saturating
module branch_predictor_bht #(
  parameter int PC_WIDTH   = 8,
  parameter int INDEX_BITS = 4,
  parameter int CTR_BITS   = 2,
  parameter int GSHARE     = 0,
  parameter int STAT_BITS  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [PC_WIDTH-1:0]   pred_pc,
  output logic                  pred_taken,
  output logic [INDEX_BITS-1:0] pred_idx,
  input  logic                  upd_valid,
  input  logic [INDEX_BITS-1:0] upd_idx,
  input  logic                  upd_taken,
  input  logic                  upd_pred_taken,
  output logic                  flush_taken,
  output logic                  flush_not_taken,
  output logic [STAT_BITS-1:0]  br_count,
  output logic [STAT_BITS-1:0]  mis_count
);

  localparam int DEPTH = 1 << INDEX_BITS;
  localparam logic [CTR_BITS-1:0]  CTR_MAX  = '1;
  localparam logic [STAT_BITS-1:0] STAT_MAX = '1;

  // Current value of every table entry, gathered for the lookup mux.
  logic [DEPTH-1:0][CTR_BITS-1:0] ctr_all;
  logic [INDEX_BITS-1:0]          ghr;

  // Only the low PC bits select an entry; the rest are deliberately ignored.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pred_pc;

  // ---------------------------------------------------------------------------
  // Counter table: one saturating counter per entry. Only the entry named by
  // upd_idx moves, so each entry decides its own next value independently.
  // ---------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_ctr
      logic [CTR_BITS-1:0] ctr_q;
      logic [CTR_BITS-1:0] ctr_d;

      always_comb begin
        ctr_d = ctr_q;
        if (upd_valid && (upd_idx == INDEX_BITS'(gi))) begin
          if (upd_taken) begin
            if (ctr_q != CTR_MAX) ctr_d = ctr_q + CTR_BITS'(1);
          end else begin
            if (ctr_q != '0) ctr_d = ctr_q - CTR_BITS'(1);
          end
        end
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) ctr_q <= '0;
        else     ctr_q <= ctr_d;
      end

      assign ctr_all[gi] = ctr_q;
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Global history: shifted by resolved outcomes only (non-speculative). The
  // lookup sees the pre-shift value in the cycle the shift is presented.
  // ---------------------------------------------------------------------------
  generate
    if (GSHARE != 0) begin : g_ghr
      logic [INDEX_BITS-1:0] ghr_q;
      logic [INDEX_BITS-1:0] ghr_d;

      always_comb begin
        ghr_d = ghr_q;
        if (upd_valid) ghr_d = (ghr_q << 1) | INDEX_BITS'(upd_taken);
      end

      always_ff @(posedge clk or posedge rst) begin
        if (rst) ghr_q <= '0;
        else     ghr_q <= ghr_d;
      end

      assign ghr = ghr_q;
    end else begin : g_no_ghr
      assign ghr = '0;
    end
  endgenerate

  // Lookup: no bypass from a same-cycle update, the stored value is used.
  assign pred_idx   = pred_pc[INDEX_BITS-1:0] ^ ghr;
  assign pred_taken = ctr_all[pred_idx][CTR_BITS-1];

  // Mispredict redirects, Mealy on the update inputs; mutually exclusive.
  assign flush_taken     = upd_valid &  upd_taken & ~upd_pred_taken;
  assign flush_not_taken = upd_valid & ~upd_taken &  upd_pred_taken;

  // ---------------------------------------------------------------------------
  // Statistics, saturating at all-ones.
  // ---------------------------------------------------------------------------
  logic [STAT_BITS-1:0] br_count_q, br_count_d;
  logic [STAT_BITS-1:0] mis_count_q, mis_count_d;

  always_comb begin
    br_count_d  = br_count_q;
    mis_count_d = mis_count_q;
    if (upd_valid && (br_count_q != STAT_MAX)) begin
      br_count_d = br_count_q + STAT_BITS'(1);
    end
    if ((flush_taken || flush_not_taken) && (mis_count_q != STAT_MAX)) begin
      mis_count_d = mis_count_q + STAT_BITS'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      br_count_q  <= '0;
      mis_count_q <= '0;
    end else begin
      br_count_q  <= br_count_d;
      mis_count_q <= mis_count_d;
    end
  end

  assign br_count  = br_count_q;
  assign mis_count = mis_count_q;

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Testbench for branch_predictor_bht. Two instances share one stimulus stream:
// dut0 uses the defaults (bimodal, 16-bit statistics), dut1 is gshare with
// 4-bit statistics so saturation is reachable. A behavioural model keeps each
// counter as an integer, the history as an integer, and the statistics as
// integers clamped at their maximum.
module tb_branch_predictor_bht;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] pred_pc;
  logic       upd_valid;
  logic [3:0] upd_idx;
  logic       upd_taken;
  logic       upd_pred_taken;

  logic        pred_taken0, flush_taken0, flush_not_taken0;
  logic [3:0]  pred_idx0;
  logic [15:0] br_count0, mis_count0;

  logic        pred_taken1, flush_taken1, flush_not_taken1;
  logic [3:0]  pred_idx1;
  logic [3:0]  br_count1, mis_count1;

  always #5 clk = ~clk;

  branch_predictor_bht dut0 (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken0),
    .pred_idx(pred_idx0), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken),
    .flush_taken(flush_taken0), .flush_not_taken(flush_not_taken0),
    .br_count(br_count0), .mis_count(mis_count0)
  );

  branch_predictor_bht #(.GSHARE(1), .STAT_BITS(4)) dut1 (
    .clk(clk), .rst(rst), .pred_pc(pred_pc), .pred_taken(pred_taken1),
    .pred_idx(pred_idx1), .upd_valid(upd_valid), .upd_idx(upd_idx),
    .upd_taken(upd_taken), .upd_pred_taken(upd_pred_taken),
    .flush_taken(flush_taken1), .flush_not_taken(flush_not_taken1),
    .br_count(br_count1), .mis_count(mis_count1)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state
  int ctr0[16];
  int ctr1[16];
  int ghr1;
  int br0, mis0, br1, mis1;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) begin
      ctr0[i] = 0;
      ctr1[i] = 0;
    end
    ghr1 = 0; br0 = 0; mis0 = 0; br1 = 0; mis1 = 0;
  endtask

  // Compare every output of both instances against the model.
  task automatic compare_all();
    int e_idx0, e_idx1, e_ft, e_fnt;
    e_idx0 = int'(pred_pc) % 16;
    e_idx1 = e_idx0 ^ ghr1;
    e_ft   = (upd_valid && upd_taken && !upd_pred_taken) ? 1 : 0;
    e_fnt  = (upd_valid && !upd_taken && upd_pred_taken) ? 1 : 0;
    check("idx0",  int'(pred_idx0), e_idx0);
    check("pred0", int'(pred_taken0), (ctr0[e_idx0] >= 2) ? 1 : 0);
    check("idx1",  int'(pred_idx1), e_idx1);
    check("pred1", int'(pred_taken1), (ctr1[e_idx1] >= 2) ? 1 : 0);
    check("ft0",   int'(flush_taken0), e_ft);
    check("fnt0",  int'(flush_not_taken0), e_fnt);
    check("ft1",   int'(flush_taken1), e_ft);
    check("fnt1",  int'(flush_not_taken1), e_fnt);
    check("br0",   int'(br_count0), br0);
    check("mis0",  int'(mis_count0), mis0);
    check("br1",   int'(br_count1), br1);
    check("mis1",  int'(mis_count1), mis1);
  endtask

  task automatic model_update();
    int i;
    if (!upd_valid) return;
    i = int'(upd_idx);
    if (upd_taken) begin
      ctr0[i] = (ctr0[i] < 3) ? ctr0[i] + 1 : 3;
      ctr1[i] = (ctr1[i] < 3) ? ctr1[i] + 1 : 3;
    end else begin
      ctr0[i] = (ctr0[i] > 0) ? ctr0[i] - 1 : 0;
      ctr1[i] = (ctr1[i] > 0) ? ctr1[i] - 1 : 0;
    end
    ghr1 = (ghr1 * 2 + (upd_taken ? 1 : 0)) % 16;
    br0 = (br0 < 65535) ? br0 + 1 : 65535;
    br1 = (br1 < 15) ? br1 + 1 : 15;
    if (upd_taken != upd_pred_taken) begin
      mis0 = (mis0 < 65535) ? mis0 + 1 : 65535;
      mis1 = (mis1 < 15) ? mis1 + 1 : 15;
    end
  endtask

  // One transaction: drive after the falling edge, check, take the rising edge.
  task automatic step(input logic [7:0] pc, input logic v, input logic [3:0] idx,
                      input logic t, input logic p);
    pred_pc = pc; upd_valid = v; upd_idx = idx; upd_taken = t; upd_pred_taken = p;
    #1;
    compare_all();
    $display("txn pc=%02h v=%0d idx=%0d t=%0d p=%0d idx0=%0d pred0=%0d idx1=%0d pred1=%0d br0=%0d mis0=%0d",
             pc, v, idx, t, p, pred_idx0, pred_taken0, pred_idx1, pred_taken1, br_count0, mis_count0);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic peek(input logic [7:0] pc);
    pred_pc = pc; upd_valid = 1'b0;
    #1;
    compare_all();
  endtask

  // Reset pulse between clock edges; state must clear immediately.
  task automatic pulse_reset();
    rst = 1'b1;
    #1;
    model_reset();
    compare_all();
    rst = 1'b0;
  endtask

  logic [7:0] r_pc;
  logic [3:0] r_idx;
  logic       r_v, r_t, r_p;
  int         b_exp, m_exp;

  initial begin
    rst = 1'b1; pred_pc = 8'h00; upd_valid = 1'b0; upd_idx = 4'h0;
    upd_taken = 1'b0; upd_pred_taken = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;

    // Reset defaults
    peek(8'h05);
    check("rst_idx", int'(pred_idx0), 5);
    check("rst_pred", int'(pred_taken0), 0);
    check("rst_br", int'(br_count0), 0);
    check("rst_mis", int'(mis_count0), 0);

    // Counter walk on entry 5
    for (int k = 0; k < 4; k++) begin
      step(8'h05, 1'b1, 4'd5, 1'b1, (ctr0[5] >= 2));
      peek(8'h05);
      check("walk_up", int'(pred_taken0), (k >= 1) ? 1 : 0);
    end
    step(8'h05, 1'b1, 4'd5, 1'b0, 1'b1);
    peek(8'h05);
    check("walk_dn1", int'(pred_taken0), 1);
    step(8'h05, 1'b1, 4'd5, 1'b0, 1'b1);
    step(8'h05, 1'b1, 4'd5, 1'b0, 1'b0);
    peek(8'h05);
    check("walk_dn3", int'(pred_taken0), 0);

    // Mispredict flush and statistics
    b_exp = br0 + 1; m_exp = mis0 + 1;
    step(8'h07, 1'b1, 4'd7, 1'b1, 1'b0);
    check("flush_br", int'(br_count0), b_exp);
    check("flush_mis", int'(mis_count0), m_exp);
    pred_pc = 8'h07; upd_valid = 1'b0; upd_taken = 1'b1; upd_pred_taken = 1'b0;
    #1;
    check("noflush_ft", int'(flush_taken0), 0);
    step(8'h07, 1'b0, 4'd7, 1'b1, 1'b0);
    check("noflush_br", int'(br_count0), b_exp);
    check("noflush_mis", int'(mis_count0), m_exp);

    // Same-cycle lookup and update, no bypass
    step(8'h03, 1'b1, 4'd3, 1'b1, 1'b0);
    pred_pc = 8'h03; upd_valid = 1'b1; upd_idx = 4'd3; upd_taken = 1'b1; upd_pred_taken = 1'b0;
    #1;
    check("same_old", int'(pred_taken0), 0);
    step(8'h03, 1'b1, 4'd3, 1'b1, 1'b0);
    peek(8'h03);
    check("same_new", int'(pred_taken0), 1);

    // Gshare history
    pulse_reset();
    step(8'h00, 1'b1, 4'd0, 1'b1, 1'b0);
    step(8'h00, 1'b1, 4'd0, 1'b1, 1'b0);
    step(8'h00, 1'b1, 4'd0, 1'b0, 1'b0);
    peek(8'h0F);
    check("gshare_idx", int'(pred_idx1), 9);

    // Statistics saturation on the 4-bit instance
    pulse_reset();
    for (int k = 0; k < 20; k++) step(8'h11, 1'b1, 4'd1, 1'b1, 1'b0);
    peek(8'h11);
    check("sat_br1", int'(br_count1), 15);
    check("sat_mis1", int'(mis_count1), 15);
    check("sat_br0", int'(br_count0), 20);
    check("sat_mis0", int'(mis_count0), 20);
    pulse_reset();
    check("prst_br1", int'(br_count1), 0);

    // Reset held across an edge discards the update presented then
    rst = 1'b1; upd_valid = 1'b1; upd_idx = 4'd2; upd_taken = 1'b1; upd_pred_taken = 1'b0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    peek(8'h02);
    check("held_br0", int'(br_count0), 0);

    // Randomised traffic against the model
    for (int n = 0; n < 400; n++) begin
      if ($urandom_range(0, 59) == 0) pulse_reset();
      r_pc  = 8'($urandom);
      r_v   = ($urandom_range(0, 3) != 0);
      r_idx = 4'($urandom_range(0, 15));
      r_t   = 1'($urandom);
      r_p   = ($urandom_range(0, 1) == 0) ? 1'($urandom) : (ctr0[r_idx] >= 2);
      step(r_pc, r_v, r_idx, r_t, r_p);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
